// File: rtl/aes_kx_pkg.sv
// Shared types, constants and helpers for the word-serial AES key-schedule engine.
package aes_kx_pkg;

  localparam logic [1:0] KLEN_128 = 2'b00;
  localparam logic [1:0] KLEN_192 = 2'b01;
  localparam logic [1:0] KLEN_256 = 2'b10;
  localparam logic [1:0] KLEN_RSV = 2'b11;

  typedef enum logic [0:0] {KX_IDLE, KX_GEN} kx_state_e;

  // One output beat as seen by the consumer: {last, round index, round key}
  typedef struct packed {
    logic         last;
    logic [3:0]   idx;
    logic [127:0] rk;
  } rk_beat_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] klen);
    case (klen)
      KLEN_192: return 4'd6;
      KLEN_256: return 4'd8;
      default:  return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] klen);
    case (klen)
      KLEN_192: return 4'd12;
      KLEN_256: return 4'd14;
      default:  return 4'd10;
    endcase
  endfunction

  // Total schedule words 4*(Nr+1)
  function automatic logic [5:0] words_of(input logic [1:0] klen);
    return {nr_of(klen) + 4'd1, 2'b00};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four forward S-boxes applied bytewise to a 32-bit word.
module aes_subword
  import aes_kx_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout_c
);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    assign dout_c[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expand_gen.sv
// Word-serial AES-128/192/256 key schedule emitting 128-bit round keys on a
// valid/ready stream with abort/restart and completion/error pulses.
module aes_key_expand_gen
  import aes_kx_pkg::*;
#(
  parameter int unsigned MAX_KEY_BITS = 256,
  parameter int unsigned RK_IDX_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                kld,
  input  logic [1:0]          klen,
  input  logic [255:0]        key,
  output logic [127:0]        rk,
  output logic [RK_IDX_W-1:0] rk_idx,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic                rk_last,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned MAX_NK = MAX_KEY_BITS / 32;
  localparam int unsigned NK_IW  = $clog2(MAX_NK);

  kx_state_e state_q, state_d;

  logic [31:0]         win_q [MAX_NK];
  logic [31:0]         asm_q [3];
  logic [1:0]          asm_cnt_q;
  logic [5:0]          i_q, wtot_q;
  logic [3:0]          nk_q, nr_q, mod_q;
  logic [7:0]          rcon_q;
  logic [RK_IDX_W-1:0] round_q;

  logic        klen_bad_c, hs_c, last_hs_c, out_free_c, gen_c, key_phase_c;
  logic [31:0] prev_c, sub_in_c, sub_out_c, t_c, new_c;

  assign klen_bad_c  = (klen == KLEN_RSV) || (32'(nk_of(klen)) > MAX_NK);
  assign hs_c        = rk_valid && rk_ready;
  assign last_hs_c   = hs_c && rk_last;
  assign out_free_c  = !rk_valid || rk_ready;
  assign gen_c       = (state_q == KX_GEN) && (i_q < wtot_q) &&
                       !((asm_cnt_q == 2'd3) && !out_free_c);
  assign key_phase_c = i_q < {2'b00, nk_q};

  // Window holds w[i-Nk..i-1] oldest first; during the key phase it rotates the key words.
  assign prev_c   = win_q[NK_IW'(nk_q - 4'd1)];
  assign sub_in_c = (mod_q == 4'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;

  aes_subword u_subword (
    .din    (sub_in_c),
    .dout_c (sub_out_c)
  );

  assign t_c   = (mod_q == 4'd0)                      ? (sub_out_c ^ {rcon_q, 24'h0}) :
                 ((nk_q == 4'd8) && (mod_q == 4'd4))  ? sub_out_c : prev_c;
  assign new_c = key_phase_c ? win_q[0] : (win_q[0] ^ t_c);

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) state_q <= KX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin : p_next
    state_d = state_q;
    if (kld)                                    state_d = klen_bad_c ? KX_IDLE : KX_GEN;
    else if ((state_q == KX_GEN) && last_hs_c)  state_d = KX_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_data
    if (!rst_n) begin
      for (int j = 0; j < MAX_NK; j++) win_q[j] <= '0;
      for (int j = 0; j < 3; j++)      asm_q[j] <= '0;
      asm_cnt_q <= '0;
      i_q       <= '0;
      wtot_q    <= '0;
      nk_q      <= '0;
      nr_q      <= '0;
      mod_q     <= '0;
      rcon_q    <= 8'h01;
      round_q   <= '0;
      rk        <= '0;
      rk_idx    <= '0;
      rk_valid  <= 1'b0;
      rk_last   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      busy <= (state_d == KX_GEN);
      err  <= kld && klen_bad_c;
      done <= !kld && last_hs_c;
      if (kld) begin
        // Restart wins over everything, including a handshake in this cycle
        for (int j = 0; j < MAX_NK; j++) win_q[j] <= key[255 - 32*j -: 32];
        for (int j = 0; j < 3; j++)      asm_q[j] <= '0;
        asm_cnt_q <= '0;
        i_q       <= '0;
        wtot_q    <= words_of(klen);
        nk_q      <= nk_of(klen);
        nr_q      <= nr_of(klen);
        mod_q     <= '0;
        rcon_q    <= 8'h01;
        round_q   <= '0;
        rk        <= '0;
        rk_idx    <= '0;
        rk_valid  <= 1'b0;
        rk_last   <= 1'b0;
      end else begin
        if (hs_c) rk_valid <= 1'b0;
        if (gen_c) begin
          for (int j = 0; j < MAX_NK; j++) begin
            if (j == int'(nk_q) - 1) win_q[j] <= new_c;
            else                     win_q[j] <= win_q[NK_IW'((j + 1) % MAX_NK)];
          end
          i_q   <= i_q + 6'd1;
          mod_q <= (mod_q == nk_q - 4'd1) ? 4'd0 : mod_q + 4'd1;
          if (!key_phase_c && (mod_q == 4'd0)) rcon_q <= xtime(rcon_q);
          if (asm_cnt_q == 2'd3) begin
            rk        <= {asm_q[0], asm_q[1], asm_q[2], new_c};
            rk_idx    <= round_q;
            rk_last   <= (round_q == RK_IDX_W'(nr_q));
            rk_valid  <= 1'b1;
            round_q   <= round_q + RK_IDX_W'(1);
            asm_cnt_q <= '0;
          end else begin
            asm_q[asm_cnt_q] <= new_c;
            asm_cnt_q        <= asm_cnt_q + 2'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expand_gen.sv
// Scoreboard bench for aes_key_expand_gen with an independent key-schedule model.
module tb_aes_key_expand_gen;
  import aes_kx_pkg::*;

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] RK12_192 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] RK14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic         clk = 1'b0, rst_n = 1'b1, kld = 1'b0, rk_ready = 1'b0;
  logic [1:0]   klen = 2'b00;
  logic [255:0] key = '0;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid, rk_last, busy, done, err;

  int checks = 0;
  int errors = 0;
  rk_beat_t exp_q[$];
  logic [7:0] sb_t [256];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;

  aes_key_expand_gen #(.MAX_KEY_BITS(256), .RK_IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .kld(kld), .klen(klen), .key(key),
    .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_last(rk_last), .busy(busy), .done(done), .err(err)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb_t[x[31:24]], sb_t[x[23:16]], sb_t[x[15:8]], sb_t[x[7:0]]};
  endfunction

  task automatic build_expected(input logic [1:0] kl, input logic [255:0] k);
    int nk, nr, nw;
    logic [31:0] w [60];
    logic [31:0] t;
    rk_beat_t e;
    nk = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
    nr = nk + 6;
    nw = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0)                 t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.last = (r == nr);
      e.idx  = 4'(r);
      e.rk   = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  task automatic do_kld(input logic [1:0] kl, input logic [255:0] k);
    kld  = 1'b1;
    klen = kl;
    key  = k;
    @(negedge clk);
    kld  = 1'b0;
  endtask

  // Accepts beats from cycle 1 after a load, popping the scoreboard on every handshake
  task automatic drain(input int duty, input int budget, input logic [127:0] final_rk,
                       output int first_cyc, output int last_cyc);
    int cyc;
    logic stall;
    logic [132:0] held;
    rk_beat_t e;
    cyc = 1; stall = 1'b0; held = '0; first_cyc = -1; last_cyc = -1;
    while (exp_q.size() > 0 && cyc < budget) begin
      if (stall) begin
        checks++;
        if (!rk_valid || {rk_last, rk_idx, rk} !== held) begin
          errors++;
          $display("FAIL hold cyc=%0d got=%h v=%b exp=%h", cyc, {rk_last, rk_idx, rk}, rk_valid, held);
        end
      end
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL early_done cyc=%0d got=%b exp=0", cyc, done);
      end
      rk_ready = ($urandom_range(99) < duty);
      if (rk_valid && first_cyc < 0) first_cyc = cyc;
      if (rk_valid && rk_ready) begin
        e = exp_q.pop_front();
        checks++;
        if ({rk_last, rk_idx, rk} !== e) begin
          errors++;
          $display("FAIL beat cyc=%0d got=%h exp=%h", cyc, {rk_last, rk_idx, rk}, e);
        end
        if (e.last) begin
          last_cyc = cyc;
          checks++;
          if (rk !== final_rk) begin
            errors++;
            $display("FAIL known_vector got=%h exp=%h", rk, final_rk);
          end
        end
      end
      stall = rk_valid && !rk_ready;
      held  = {rk_last, rk_idx, rk};
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL timeout left=%0d exp=0", exp_q.size());
      exp_q.delete();
    end else if (done !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b v=%b exp 1 0 0", done, busy, rk_valid);
    end
    rk_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rk, rk_idx, rk_valid, rk_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL reset got=%h exp=0", {rk, rk_idx, rk_valid, rk_last, busy, done, err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_k128();
    int f, l;
    build_expected(KLEN_128, KEY128);
    do_kld(KLEN_128, KEY128);
    checks++;
    if (busy !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_start got busy=%b v=%b exp 1 0", busy, rk_valid);
    end
    drain(100, 200, RK10_128, f, l);
    checks++;
    if (f != 5 || l != 45) begin
      errors++;
      $display("FAIL latency128 got first=%0d last=%0d exp 5 45", f, l);
    end
  endtask

  task automatic test_k192();
    int f, l;
    build_expected(KLEN_192, KEY192);
    do_kld(KLEN_192, KEY192);
    drain(100, 200, RK12_192, f, l);
    checks++;
    if (f != 5 || l != 53) begin
      errors++;
      $display("FAIL latency192 got first=%0d last=%0d exp 5 53", f, l);
    end
  endtask

  task automatic test_k256();
    int f, l;
    build_expected(KLEN_256, KEY256);
    do_kld(KLEN_256, KEY256);
    drain(100, 200, RK14_256, f, l);
    checks++;
    if (f != 5 || l != 61) begin
      errors++;
      $display("FAIL latency256 got first=%0d last=%0d exp 5 61", f, l);
    end
  endtask

  task automatic test_back_pressure();
    int f, l;
    build_expected(KLEN_256, KEY256);
    do_kld(KLEN_256, KEY256);
    drain(30, 3000, RK14_256, f, l);
  endtask

  task automatic test_abort();
    int f, l, cyc;
    rk_beat_t e;
    build_expected(KLEN_256, KEY256);
    do_kld(KLEN_256, KEY256);
    rk_ready = 1'b1;
    cyc = 1;
    while (cyc < 200 && !(rk_valid && rk_idx == 4'd5)) begin
      if (rk_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({rk_last, rk_idx, rk} !== e) begin
          errors++;
          $display("FAIL abort_pre got=%h exp=%h", {rk_last, rk_idx, rk}, e);
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!(rk_valid && rk_idx == 4'd5)) begin
      errors++;
      $display("FAIL abort_reach got v=%b idx=%0d exp 1 5", rk_valid, rk_idx);
    end
    exp_q.delete();
    build_expected(KLEN_128, KEY128);
    do_kld(KLEN_128, KEY128);
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop got v=%b busy=%b done=%b exp 0 1 0", rk_valid, busy, done);
    end
    drain(100, 200, RK10_128, f, l);
    checks++;
    if (f != 5 || l != 45) begin
      errors++;
      $display("FAIL abort_latency got first=%0d last=%0d exp 5 45", f, l);
    end
  endtask

  task automatic test_invalid();
    logic bad;
    do_kld(KLEN_RSV, KEY256);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_pulse got err=%b busy=%b v=%b exp 1 0 0", err, busy, rk_valid);
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_width got=%b exp=0", err);
    end
    bad = 1'b0;
    rk_ready = 1'b1;
    repeat (10) begin
      if (busy !== 1'b0 || rk_valid !== 1'b0 || done !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    rk_ready = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL invalid_idle got activity exp none");
    end
  endtask

  task automatic test_async_reset();
    do_kld(KLEN_256, KEY256);
    rk_ready = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rk, rk_idx, rk_valid, rk_last, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0", {rk, rk_idx, rk_valid, rk_last, busy, done, err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rk_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got busy=%b v=%b exp 0 0", busy, rk_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_k128();
    test_k192();
    test_k256();
    test_back_pressure();
    test_abort();
    test_invalid();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_gen.md
Name: aes_key_expand_gen

Overview:
- Parametrised, word-serial AES key-schedule engine for 128/192/256-bit keys, selected at load time.
- Produces round keys 0..Nr in order as 128-bit beats on a valid/ready stream, tagged with the round index.
- Sits between the key register file and the cipher/inverse-cipher round pipeline, or a round-key RAM writer.
- Generalises the fixed 128-bit, free-running key expander with key-length modes, back-pressure, abort/restart and completion/error signalling.

Parameters:
- MAX_KEY_BITS, 256, largest supported key (128, 192 or 256); sets window depth MAX_NK = MAX_KEY_BITS/32.
- RK_IDX_W, 4, width of round-index output (must hold 14).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- kld  in  1  load strobe; samples key/klen; restarts the engine in any state
- klen  in  2  00 = 128-bit, 01 = 192-bit, 10 = 256-bit, 11 = reserved
- key  in  256  key, MSB-aligned: word0 = key[255:224]; unused low bits ignored
- rk  out  128  round key, word w[4r] in rk[127:96]
- rk_idx  out  RK_IDX_W  round index r of rk
- rk_valid  out  1  rk/rk_idx/rk_last valid
- rk_ready  in  1  consumer accepts beat when rk_valid & rk_ready
- rk_last  out  1  beat is round Nr
- busy  out  1  generation in progress (GEN state)
- done  out  1  one-cycle pulse after the last beat is accepted
- err  out  1  one-cycle pulse: kld with klen = 11 or key length > MAX_KEY_BITS

Behaviour:
- Reset: all outputs 0; state IDLE; rcon = 0x01; counters 0.
- Derived values: Nk = 4/6/8, Nr = 10/12/14, total words W = 4(Nr+1) = 44/52/60.
- States: IDLE, GEN.
  - IDLE -> GEN on a valid kld.
  - GEN -> IDLE when the rk_last beat handshakes (done pulses in the cycle after).
  - Invalid kld: err pulses the next cycle; state goes to IDLE; no beats are produced.
- kld at cycle 0:
  - Load the window with the key words, set word index i = 0, rcon = 0x01, clear the assembly and output registers.
  - rk_valid drops in cycle 1 if it was high (abort mid-run is permitted).
  - kld has priority over every other event, including a simultaneous handshake; that handshake is discarded.
- Word generation, one word per enabled cycle:
  - i < Nk: the word is key word i.
  - i >= Nk: w[i] = w[i-Nk] ^ t.
  - t = SubWord(RotWord(w[i-1])) ^ {rcon, 24'h0} when i mod Nk == 0; rcon then advances by xtime (0x80 -> 0x1B; 0x36 is the last used for 128-bit).
  - t = SubWord(w[i-1]) when Nk == 8 and i mod Nk == 4.
  - Otherwise t = w[i-1].
  - The window shifts in w[i]; i increments.
- Assembly: generated words fill a 4-word assembly register. On the 4th word, the contents move to the output register if that register is empty or being accepted this cycle.
- Stall: generation is disabled when the assembly register is full and the output register cannot take it. No word is lost or duplicated under arbitrary rk_ready patterns.
- Generation stops after word W-1.
- Latency: word j is registered at the end of cycle j+1. With rk_ready = 1:
  - rk_valid for round 0 first appears in cycle 5.
  - Each following round appears every 4 cycles (round r valid in cycle 5+4r).
  - 128-bit: last beat in cycle 45, done in cycle 46.
- rk, rk_idx and rk_last are held stable while rk_valid & !rk_ready.
- busy = 1 from cycle 1 after a valid kld until the last handshake.
- Asserting rst_n low mid-run returns to the reset state immediately (asynchronously).

Decomposition:
- Package aes_kx_pkg holds:
  - klen encoding constants
  - Nk/Nr lookup functions
  - word-count function
  - xtime function
  - state enum
- Sub-module aes_subword: four existing sbox instances in encrypt mode, with a 32-bit in/out interface. It is instanced once; the rotation mux sits in front of it.

Test Plan:
- 128-bit key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1 -> 11 beats, rk_idx 0..10; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last; done in cycle 46.
- 192-bit key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 beats; rk12 = e98ba06f448c773c8ecc720401002202.
- 256-bit key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 beats; rk14 = fe4890d1e6188d0b046df344706c631e.
- Random rk_ready (≈30% duty) on the 256-bit case -> identical beat sequence; rk held stable during stalls.
- kld with the 128-bit key at round 5 of a 256-bit run -> rk_valid low next cycle; the restarted 128-bit sequence is correct; no done from the aborted run.
- kld with klen = 11 -> err pulse; busy and rk_valid stay 0. Async reset asserted mid-run -> all outputs 0 at once.
